// File: rtl/ram_responder_pkg.sv
// Shared constants and types for the RAM responder and its read pipeline.
// Bus widths match the memory controller's defaults.
package ram_responder_pkg;

  localparam int          RR_ADDR_W   = 18;
  localparam int          RR_DATA_W   = 16;
  localparam logic [15:0] RR_OOB_DATA = 16'h0000;
  localparam int          RR_LAT_MIN  = 0;
  localparam int          RR_LAT_MAX  = 4;

  typedef enum logic [1:0] {
    RR_IDLE,
    RR_READING,
    RR_TURN
  } rr_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid+data shift register carrying launched reads to the bus, DEPTH cycles deep.
// Accepts one read per cycle with no stall; busy is the OR of all stage valids.
module ram_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int DAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  output logic [DAT_W-1:0] out_dat,
  output logic             busy
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DAT_W-1:0] dat_q [DEPTH];
  logic [DAT_W-1:0] dat_d [DEPTH];

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_vld;
    dat_d[0] = in_dat;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Only the valids are reset; payload is don't-care while its valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
    dat_q <= dat_d;
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];
  assign busy    = |vld_q;

endmodule

// File: rtl/ram_responder.sv
// RAM end of the controller interface: stores writes, returns reads READ_LATENCY cycles later.
// No backpressure; a write colliding with due read data wins and the read is dropped.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W       = RR_ADDR_W,
  parameter int DATA_W       = RR_DATA_W,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mc_ram_addr,
  input  logic              mc_ram_wre,
  inout  wire  [DATA_W-1:0] mc_ram_data,
  output logic              ram_busy,
  output logic              ram_conflict,
  output logic              ram_oob,
  output logic [15:0]       ram_wr_count,
  output logic [15:0]       ram_rd_count
);

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_oob, launch, wr_en, out_vld, drive_en;
  logic [DATA_W-1:0]     rd_dat, out_dat;
  logic [15:0]           wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  rr_state_e             state_q, state_d;

  assign idx      = mc_ram_addr[DEPTH_LOG2-1:0];
  assign addr_oob = (mc_ram_addr >> DEPTH_LOG2) != '0;
  assign launch   = reset && !mc_ram_wre;
  assign wr_en    = reset && mc_ram_wre && !addr_oob;
  assign rd_dat   = addr_oob ? DATA_W'(RR_OOB_DATA) : mem[idx];

  // Array is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= mc_ram_data;
  end

  generate
    if (READ_LATENCY == 0) begin : g_async
      assign out_vld  = launch;
      assign out_dat  = rd_dat;
      assign ram_busy = 1'b0;
    end else begin : g_pipe
      ram_rd_pipe #(
        .DEPTH (READ_LATENCY),
        .DAT_W (DATA_W)
      ) u_rd_pipe (
        .clk     (clock),
        .rst_n   (reset),
        .in_vld  (launch),
        .in_dat  (rd_dat),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .busy    (ram_busy)
      );
    end
  endgenerate

  assign drive_en    = out_vld && !mc_ram_wre;
  assign mc_ram_data = drive_en ? out_dat : 'z;
  assign ram_oob     = reset && addr_oob;

  always_comb begin
    state_d      = RR_IDLE;
    ram_conflict = 1'b0;
    if (reset) begin
      if (out_vld && mc_ram_wre && state_q != RR_IDLE) begin
        state_d      = RR_TURN;
        ram_conflict = 1'b1;
      end else if (launch || ram_busy) begin
        state_d = RR_READING;
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q + 16'(wr_en);
    rd_count_d = rd_count_q + 16'(drive_en);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= RR_IDLE;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign ram_wr_count = wr_count_q;
  assign ram_rd_count = rd_count_q;

endmodule
